// File: rtl/sseg_pkg.sv
// Shared definitions for the four-digit seven-segment scan controller.
//   digit_idx_t : 2-bit index of the digit currently being scanned
//   AN_ONEHOT   : active-low anode pattern per digit index
//   AN_ALL_OFF  : all anodes dark
//   SEG_BLANK   : all segments and the decimal point dark
//   nibble_of() : selects the hex nibble shown on a given digit
package sseg_pkg;

  typedef logic [1:0] digit_idx_t;

  localparam int               SUPPORTED_DIGITS = 4;
  localparam logic [3:0]       AN_ALL_OFF       = 4'b1111;
  localparam logic [3:0]       AN_ONEHOT [4]    = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
  localparam logic [7:0]       SEG_BLANK        = 8'hFF;

  function automatic logic [3:0] nibble_of(input logic [15:0] word, input digit_idx_t idx);
    return word[{idx, 2'b00} +: 4];
  endfunction

endpackage

// File: rtl/binary_to_seven_seg.sv
// Hex nibble to seven-segment glyph decoder (purely combinational).
//   bin : nibble to display
//   dp  : decimal point request, 1 = lit (passed through on seg[7], active-high)
//   seg : seg[6:0] = segments g..a active-low, seg[7] = dp as given
module binary_to_seven_seg (
  input  logic [3:0] bin,
  input  logic       dp,
  output logic [7:0] seg
);

  always_comb begin
    // NOTE: default first so every path assigns seg; a missing branch would otherwise infer a latch.
    seg = {dp, 7'b1111111};
    case (bin)
      4'h0: seg[6:0] = 7'b1000000;
      4'h1: seg[6:0] = 7'b1111001;
      4'h2: seg[6:0] = 7'b0100100;
      4'h3: seg[6:0] = 7'b0110000;
      4'h4: seg[6:0] = 7'b0011001;
      4'h5: seg[6:0] = 7'b0010010;
      4'h6: seg[6:0] = 7'b0000010;
      4'h7: seg[6:0] = 7'b1111000;
      4'h8: seg[6:0] = 7'b0000000;
      4'h9: seg[6:0] = 7'b0010000;
      4'hA: seg[6:0] = 7'b0001000;
      4'hB: seg[6:0] = 7'b0000011;
      4'hC: seg[6:0] = 7'b1000110;
      4'hD: seg[6:0] = 7'b0100001;
      4'hE: seg[6:0] = 7'b0000110;
      4'hF: seg[6:0] = 7'b0001110;
      default: seg[6:0] = 7'b1111111;
    endcase
  end

endmodule

// File: rtl/sseg_scan_controller.sv
// Time-multiplexed driver for a four-digit common-anode seven-segment display.
// A prescaler paces the digit scan; updates are double-buffered (pending ->
// shadow) and committed only when the scan wraps from digit 3 to digit 0 so a
// frame never shows a mix of old and new digits.
//   clk      : system clock, rising edge
//   rst      : synchronous active-high reset
//   load     : one-cycle update request, samples value/dp_in
//   value    : four hex nibbles, digit 0 = value[3:0]
//   dp_in    : decimal point per digit, 1 = lit
//   blank    : level, 1 darkens every anode (scan keeps running)
//   load_ack : one-cycle pulse when pending data reaches the display
//   busy     : an update is pending and not yet committed
//   an       : active-low anodes
//   sseg     : active-low segments a..g in bits 0..6, dp in bit 7
// Optional build macro SSEG_LEADING_ZERO_BLANK_EN: darkens digits above the
// highest nonzero nibble (digit 0 and digits with a lit dp always shown).
module sseg_scan_controller
  import sseg_pkg::*;
#(
  parameter int DIGIT_PERIOD = 100000,
  parameter int NUM_DIGITS   = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [15:0] value,
  input  logic [3:0]  dp_in,
  input  logic        blank,
  output logic        load_ack,
  output logic        busy,
  output logic [3:0]  an,
  output logic [7:0]  sseg
);

  if (NUM_DIGITS != SUPPORTED_DIGITS) begin : g_bad_num_digits
    $error("sseg_scan_controller: NUM_DIGITS must be 4");
  end
  if (DIGIT_PERIOD < 2 || DIGIT_PERIOD > (1 << 20)) begin : g_bad_period
    $error("sseg_scan_controller: DIGIT_PERIOD must be in 2..2^20");
  end

  localparam int              CNT_W    = (DIGIT_PERIOD > 2) ? $clog2(DIGIT_PERIOD) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIGIT_PERIOD - 1);

  logic [CNT_W-1:0] presc;
  digit_idx_t       index;
  logic             tick;
  logic             commit;
  logic [15:0]      value_pend;
  logic [3:0]       dp_pend;
  logic [15:0]      value_sh;
  logic [3:0]       dp_sh;
  logic [7:0]       dec_seg;
  logic             digit_on;

  assign tick   = (presc == CNT_LAST);
  // Frame boundary: the tick that moves the scan from digit 3 back to digit 0.
  assign commit = tick && (index == 2'd3) && busy;

  binary_to_seven_seg u_dec (
    .bin (nibble_of(value_sh, index)),
    .dp  (dp_sh[index]),
    .seg (dec_seg)
  );

`ifdef SSEG_LEADING_ZERO_BLANK_EN
  // A digit stays lit if it is digit 0, carries a lit dp, or any nibble at or
  // above it is nonzero.
  always_comb begin
    digit_on = 1'b1;
    if (index != 2'd0) begin
      digit_on = dp_sh[index] || ((value_sh >> {index, 2'b00}) != 16'h0000);
    end
  end
`else
  assign digit_on = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      presc      <= '0;
      index      <= '0;
      value_pend <= '0;
      dp_pend    <= '0;
      value_sh   <= '0;
      dp_sh      <= '0;
      busy       <= 1'b0;
      load_ack   <= 1'b0;
      an         <= AN_ALL_OFF;
      sseg       <= SEG_BLANK;
    end else begin
      presc <= tick ? '0 : presc + CNT_W'(1);
      if (tick) begin
        index <= index + 2'd1;
      end

      load_ack <= 1'b0;
      // NOTE: non-blocking assignments let the commit copy the old pending
      // data even when a load overwrites the pending registers this same cycle.
      if (commit) begin
        value_sh <= value_pend;
        dp_sh    <= dp_pend;
        busy     <= 1'b0;
        load_ack <= 1'b1;
      end
      // Placed after the commit so a coinciding load keeps busy set.
      if (load) begin
        value_pend <= value;
        dp_pend    <= dp_in;
        busy       <= 1'b1;
      end

      // Anode and segments are registered together so they switch on the same edge.
      if (blank || !digit_on) begin
        an   <= AN_ALL_OFF;
        sseg <= SEG_BLANK;
      end else begin
        an   <= AN_ONEHOT[index];
        sseg <= {~dec_seg[7], dec_seg[6:0]};
      end
    end
  end

endmodule
